// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: memory read port, instruction handshake and redirect.
// The master modport is the fetch unit; the slave modport is memory plus consumer.
interface ifetch_unit_if;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_read,
        output mem_address,
        input  mem_rdata,
        input  mem_resp,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        output mem_rdata,
        output mem_resp,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// LC-3b instruction fetch front end: PC sequencing, single outstanding read,
// and a small FIFO of {pc, word} entries that is flushed on redirect.
module ifetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic        mem_read_q, mem_read_d;

    logic [15:0] fifo_word_q [DEPTH];
    logic [15:0] fifo_pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        resp_ok;
    logic        push;
    logic        pop;
    logic        fifo_valid;
    logic [15:0] redirect_target;

    assign redirect_target = bus.redirect_pc & 16'hFFFE;
    // A response only counts while a request is actually being driven.
    assign resp_ok         = bus.mem_resp & mem_read_q;
    assign fifo_valid      = (count_q != '0);
    assign pop             = fifo_valid & bus.instr_ready;

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_address_q;
    assign bus.instr_valid = fifo_valid;
    assign bus.instr       = fifo_valid ? fifo_word_q[rd_ptr_q] : 16'h0000;
    assign bus.instr_pc    = fifo_valid ? fifo_pc_q[rd_ptr_q]   : 16'h0000;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        push          = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (count_q < DEPTH_C) begin
                    state_d       = REQ;
                    mem_read_d    = 1'b1;
                    mem_address_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    fetch_pc_d = redirect_target;
                    if (resp_ok) begin
                        state_d    = IDLE;
                        mem_read_d = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (resp_ok) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    state_d    = IDLE;
                    mem_read_d = 1'b0;
                end
            end
            DROP: begin
                // The stale request must stay up until memory answers it.
                if (bus.redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (resp_ok) begin
                    state_d    = IDLE;
                    mem_read_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_address_q <= RESET_PC;
            mem_read_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_word_q[i] <= 16'h0000;
                fifo_pc_q[i]   <= 16'h0000;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (push && !bus.redirect) begin
                fifo_word_q[wr_ptr_q] <= bus.mem_rdata;
                fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
            end
        end
    end
endmodule
